sym_dn_lut_loader: RTL

- Write-side feeder for the symmetric decision-node IB LUT RAM bit-slices (one 2-bank slice per quantisation bit).
- Accepts a valid/ready stream of LUT entries; each beat carries one entry for bank0 and one for bank1.
- Sequences the entries into one frame page (selected by the address offset) and drives the slices' write port: lut_in_bank0/1, page_write_addr, write_addr_offset, we.
- Bit i of each data vector goes to rank slice i.

---
 rtl/sym_dn_lut_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sym_dn_lut_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sym_dn_lut_loader: streams LUT entry pairs into one frame page of the     |
// | symmetric decision-node IB LUT bit-slices.            Rev 1.0             |
// +--------------------------------------------------------------------------+
module sym_dn_lut_loader #(
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int QUAN_SIZE       = 3,
  localparam int OFF_W          = $clog2(MULTI_FRAME_NUM),
  localparam int PAGE_W         = ENTRY_ADDR - OFF_W
) (
  input  logic                 write_clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [OFF_W-1:0]     load_offset,
  input  logic                 load_abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [QUAN_SIZE-1:0] in_data_bank0,
  input  logic [QUAN_SIZE-1:0] in_data_bank1,
  output logic [QUAN_SIZE-1:0] lut_in_bank0,
  output logic [QUAN_SIZE-1:0] lut_in_bank1,
  output logic [PAGE_W-1:0]    page_write_addr,
  output logic [OFF_W-1:0]     write_addr_offset,
  output logic                 we,
  output logic                 busy,
  output logic [OFF_W-1:0]     busy_offset,
  output logic                 load_done,
  output logic                 load_aborted
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [PAGE_W-1:0]    r_cnt;
  logic [PAGE_W-1:0]    r_addr;
  logic [OFF_W-1:0]     r_woff;
  logic [OFF_W-1:0]     r_busy_off;
  logic                 r_we;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_aborted;
  logic [QUAN_SIZE-1:0] r_bank0;
  logic [QUAN_SIZE-1:0] r_bank1;

  logic w_ready;
  logic w_accept;
  logic w_last;

  // Abort wins over a beat presented in the same cycle.
  assign w_ready  = (r_state == ST_LOAD) & ~load_abort;
  assign w_accept = w_ready & in_valid;
  assign w_last   = &r_cnt;

  always_ff @(posedge write_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_woff     <= '0;
      r_busy_off <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_we      <= w_accept;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (w_accept) begin
        r_addr <= r_cnt;
        r_woff <= r_busy_off;
      end
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_state    <= ST_LOAD;
            r_busy_off <= load_offset;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_abort) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
          end else if (w_accept) begin
            r_cnt <= r_cnt + PAGE_W'(1);
            // Final entry: its write lands in DONE, alongside load_done.
            if (w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // One data register pair per rank slice; bit i feeds slice i.
  for (genvar gi = 0; gi < QUAN_SIZE; gi++) begin : g_slice
    always_ff @(posedge write_clk) begin
      if (rst) begin
        r_bank0[gi] <= 1'b0;
        r_bank1[gi] <= 1'b0;
      end else if (w_accept) begin
        r_bank0[gi] <= in_data_bank0[gi];
        r_bank1[gi] <= in_data_bank1[gi];
      end
    end
  end

  assign in_ready          = w_ready;
  assign lut_in_bank0      = r_bank0;
  assign lut_in_bank1      = r_bank1;
  assign page_write_addr   = r_addr;
  assign write_addr_offset = r_woff;
  assign we                = r_we;
  assign busy              = r_busy;
  assign busy_offset       = r_busy_off;
  assign load_done         = r_done;
  assign load_aborted      = r_aborted;

endmodule
`default_nettype wire
